mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS core. It sequences a shared-ALU, single-memory datapath through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time. Each cycle it drives the datapath's write enables and mux selects from its state register and from the opcode/funct fields of the datapath's instruction register (IR). It also handshakes with a variable-latency memory port.

---
 rtl/mc_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath enables and mux selects from the state register and the IR fields.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_LUI  = 2'd3;

  state_e state_q, state_d;

  logic is_rtype, is_addu, is_subu, is_jr;
  logic is_j, is_jal, is_beq, is_ori, is_lui, is_lw, is_sw;
  logic is_legal;

  // Instruction decode from the IR fields, valid from DECODE through WB.
  assign is_rtype = (op == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_legal = is_addu | is_subu | is_jr | is_j | is_jal | is_beq |
                    is_ori | is_lui | is_lw | is_sw;

  // NOTE: sequential state uses non-blocking assignments only; the reset is
  // sampled on the clock edge, so it is synchronous by construction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_j || is_jal || !is_legal) state_d = S_FETCH;
        else                             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw)       state_d = S_MEM;
        else if (is_beq || is_jr) state_d = S_FETCH;
        else                      state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_SEQ;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_we   = 1'b1;
          npc_sel = NPC_JMP;
          retire  = 1'b1;
          if (is_jal) begin
            reg_we  = 1'b1;
            reg_dst = DST_RA;
            wd_sel  = WD_PC;
          end
        end else if (!is_legal) begin
          illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_addu || is_subu) begin
          alu_op = is_subu ? ALU_SUB : ALU_ADD;
        end else if (is_ori) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_OR;
        end else if (is_lui) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_LUI;
        end else if (is_beq) begin
          alu_op  = ALU_SUB;
          pc_we   = zero;
          npc_sel = NPC_BR;
          retire  = 1'b1;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          npc_sel = NPC_RS;
          retire  = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src_b = 1'b1;
          ext_op    = 1'b1;
          alu_op    = ALU_ADD;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        retire  = is_sw && mem_ready;
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = is_rtype ? DST_RD : DST_RT;
        wd_sel  = is_lw ? WD_MEM : WD_ALU;
        retire  = 1'b1;
      end
      default: ;
    endcase

    // Reset abandons the instruction in the same cycle: no request, no writes.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      npc_sel   = NPC_SEQ;
      reg_we    = 1'b0;
      reg_dst   = DST_RT;
      wd_sel    = WD_ALU;
      alu_src_b = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALU_ADD;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each stimulus cycle queues its hand-computed
// control vector; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic       ext_op;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t  exp;
    ctl_t  mask;
    string tag;
  } sb_entry_t;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_LW   = 32'h8C430004;
  localparam logic [31:0] I_SW   = 32'hAC430004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_J    = 32'h08000020;
  localparam logic [31:0] I_ORI  = 32'h3421FFFF;
  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_SLL  = 32'h00000000;

  logic       clk = 1'b1;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, ext_op;
  logic       retire, illegal;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op;
  logic [2:0] state;
  ctl_t       act;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .state(state), .retire(retire), .illegal(illegal)
  );

  assign act = {state, mem_req, mem_we, ir_we, pc_we, npc_sel, reg_we, reg_dst,
                wd_sel, alu_src_b, ext_op, alu_op, retire, illegal};

  // Argument order: state, mem_req, mem_we, ir_we, pc_we, npc_sel, reg_we,
  // reg_dst, wd_sel, alu_src_b, ext_op, alu_op, retire, illegal.
  function automatic ctl_t v(input int st, req, we, irwe, pcwe, npc, regwe,
                             rdst, wds, srcb, ext, aop, ret, ill);
    return {3'(st), 1'(req), 1'(we), 1'(irwe), 1'(pcwe), 2'(npc), 1'(regwe),
            2'(rdst), 2'(wds), 1'(srcb), 1'(ext), 2'(aop), 1'(ret), 1'(ill)};
  endfunction

  task automatic cyc(input logic rst, input logic [31:0] ir, input logic z,
                     input logic rdy, input ctl_t e, input string tag,
                     input ctl_t m = '1);
    sb_entry_t ent;
    reset     = rst;
    op        = ir[31:26];
    funct     = ir[5:0];
    zero      = z;
    mem_ready = rdy;
    ent.exp   = e;
    ent.mask  = m;
    ent.tag   = tag;
    sb.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a full control vector every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      n_checks++;
      if ((act & e.mask) === (e.exp & e.mask))
        n_pass++;
      else
        $display("FAIL %s: got %05h (state %0d) expected %05h (state %0d) mask %05h",
                 e.tag, act, act.state, e.exp, e.exp.state, e.mask);
    end
  end

  ctl_t F_OK, F_WAIT, IDLE_D;

  initial begin
    F_OK   = v(0,1,0,1,1,0,0,0,0,0,0,0,0,0);
    F_WAIT = v(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    IDLE_D = v(1,0,0,0,0,0,0,0,0,0,0,0,0,0);

    // Reset held two cycles; state is unknown until the first edge.
    cyc(1, I_ADDU, 0, 1, v(0,0,0,0,0,0,0,0,0,0,0,0,0,0), "reset0",
        {3'b000, 17'h1FFFF});
    cyc(1, I_ADDU, 0, 1, v(0,0,0,0,0,0,0,0,0,0,0,0,0,0), "reset1");

    // addu: 0,1,2,4
    cyc(0, I_ADDU, 0, 1, F_OK,                           "addu_fetch");
    cyc(0, I_ADDU, 0, 1, IDLE_D,                         "addu_decode");
    cyc(0, I_ADDU, 0, 1, v(2,0,0,0,0,0,0,0,0,0,0,0,0,0), "addu_exec");
    cyc(0, I_ADDU, 0, 1, v(4,0,0,0,0,0,1,1,0,0,0,0,1,0), "addu_wb");

    // subu with a fetch wait and mem_ready low in DECODE (ignored there)
    cyc(0, I_SUBU, 0, 0, F_WAIT,                         "subu_fetch_wait");
    cyc(0, I_SUBU, 0, 1, F_OK,                           "subu_fetch");
    cyc(0, I_SUBU, 0, 0, IDLE_D,                         "subu_decode");
    cyc(0, I_SUBU, 0, 0, v(2,0,0,0,0,0,0,0,0,0,0,1,0,0), "subu_exec");
    cyc(0, I_SUBU, 0, 0, v(4,0,0,0,0,0,1,1,0,0,0,0,1,0), "subu_wb");

    // lw with three MEM wait cycles: 8 cycles total
    cyc(0, I_LW, 0, 1, F_OK,                             "lw_fetch");
    cyc(0, I_LW, 0, 1, IDLE_D,                           "lw_decode");
    cyc(0, I_LW, 0, 1, v(2,0,0,0,0,0,0,0,0,1,1,0,0,0),   "lw_exec");
    for (int i = 0; i < 3; i++)
      cyc(0, I_LW, 0, 0, v(3,1,0,0,0,0,0,0,0,0,0,0,0,0), "lw_mem_wait");
    cyc(0, I_LW, 0, 1, v(3,1,0,0,0,0,0,0,0,0,0,0,0,0),   "lw_mem_done");
    cyc(0, I_LW, 0, 1, v(4,0,0,0,0,0,1,0,1,0,0,0,1,0),   "lw_wb");

    // beq taken then not taken
    cyc(0, I_BEQ, 1, 1, F_OK,                            "beqt_fetch");
    cyc(0, I_BEQ, 1, 1, IDLE_D,                          "beqt_decode");
    cyc(0, I_BEQ, 1, 1, v(2,0,0,0,1,1,0,0,0,0,0,1,1,0),  "beqt_exec");
    cyc(0, I_BEQ, 0, 1, F_OK,                            "beqn_fetch");
    cyc(0, I_BEQ, 0, 1, IDLE_D,                          "beqn_decode");
    cyc(0, I_BEQ, 0, 1, v(2,0,0,0,0,1,0,0,0,0,0,1,1,0),  "beqn_exec");

    // jal then jr $31, then plain j
    cyc(0, I_JAL, 0, 1, F_OK,                            "jal_fetch");
    cyc(0, I_JAL, 0, 1, v(1,0,0,0,1,2,1,2,2,0,0,0,1,0),  "jal_decode");
    cyc(0, I_JR, 0, 1, F_OK,                             "jr_fetch");
    cyc(0, I_JR, 0, 1, IDLE_D,                           "jr_decode");
    cyc(0, I_JR, 0, 1, v(2,0,0,0,1,3,0,0,0,0,0,0,1,0),   "jr_exec");
    cyc(0, I_J, 0, 1, F_OK,                              "j_fetch");
    cyc(0, I_J, 0, 1, v(1,0,0,0,1,2,0,0,0,0,0,0,1,0),    "j_decode");

    // ori (zero-extended OR) and lui
    cyc(0, I_ORI, 0, 1, F_OK,                            "ori_fetch");
    cyc(0, I_ORI, 0, 1, IDLE_D,                          "ori_decode");
    cyc(0, I_ORI, 0, 1, v(2,0,0,0,0,0,0,0,0,1,0,2,0,0),  "ori_exec");
    cyc(0, I_ORI, 0, 1, v(4,0,0,0,0,0,1,0,0,0,0,0,1,0),  "ori_wb");
    cyc(0, I_LUI, 0, 1, F_OK,                            "lui_fetch");
    cyc(0, I_LUI, 0, 1, IDLE_D,                          "lui_decode");
    cyc(0, I_LUI, 0, 1, v(2,0,0,0,0,0,0,0,0,1,0,3,0,0),  "lui_exec");
    cyc(0, I_LUI, 0, 1, v(4,0,0,0,0,0,1,0,0,0,0,0,1,0),  "lui_wb");

    // Illegal opcode and illegal R-type funct
    cyc(0, I_BAD, 0, 1, F_OK,                            "bad_fetch");
    cyc(0, I_BAD, 0, 1, v(1,0,0,0,0,0,0,0,0,0,0,0,0,1),  "bad_decode");
    cyc(0, I_SLL, 0, 1, F_OK,                            "sll_fetch");
    cyc(0, I_SLL, 0, 1, v(1,0,0,0,0,0,0,0,0,0,0,0,0,1),  "sll_decode");

    // sw completing in 4 cycles
    cyc(0, I_SW, 0, 1, F_OK,                             "sw_fetch");
    cyc(0, I_SW, 0, 1, IDLE_D,                           "sw_decode");
    cyc(0, I_SW, 0, 1, v(2,0,0,0,0,0,0,0,0,1,1,0,0,0),   "sw_exec");
    cyc(0, I_SW, 0, 1, v(3,1,1,0,0,0,0,0,0,0,0,0,1,0),   "sw_mem");

    // sw stalled in MEM, then reset abandons it
    cyc(0, I_SW, 0, 1, F_OK,                             "swr_fetch");
    cyc(0, I_SW, 0, 1, IDLE_D,                           "swr_decode");
    cyc(0, I_SW, 0, 1, v(2,0,0,0,0,0,0,0,0,1,1,0,0,0),   "swr_exec");
    cyc(0, I_SW, 0, 0, v(3,1,1,0,0,0,0,0,0,0,0,0,0,0),   "swr_mem_wait");
    cyc(1, I_SW, 0, 0, v(3,0,0,0,0,0,0,0,0,0,0,0,0,0),   "swr_reset");
    cyc(0, I_SW, 0, 1, F_OK,                             "swr_after_reset");

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
